// File: rtl/fq_div_prog_if.sv
// ---------------------------------------------------------------------------
// fq_div_prog_if
//
// Purpose: groups the control and status signals of the programmable
// frequency divider so a single bundle can be passed between the divider
// and whatever block programs it.
//
// Signals:
//   en        : 1 = divider counts, 0 = counter parked and output forced low
//   load      : single-cycle request to stage div_val/mode
//   div_val   : requested divisor (CNT_W bits, must be >= 2)
//   mode      : requested output mode (0 = pulse, 1 = square)
//   div_n_clk : divided output, registered
//   load_ack  : one-cycle pulse when staged settings become active
//   load_err  : one-cycle pulse when a load is rejected (div_val < 2)
//   pending   : high while staged settings wait for a period boundary
//
// Modports:
//   master : the programming side (drives requests, observes status)
//   slave  : the divider itself
// ---------------------------------------------------------------------------
interface fq_div_prog_if #(
    parameter int unsigned CNT_W = 32
) ();

    logic             en;
    logic             load;
    logic [CNT_W-1:0] div_val;
    logic             mode;
    logic             div_n_clk;
    logic             load_ack;
    logic             load_err;
    logic             pending;

    modport master (
        output en,
        output load,
        output div_val,
        output mode,
        input  div_n_clk,
        input  load_ack,
        input  load_err,
        input  pending
    );

    modport slave (
        input  en,
        input  load,
        input  div_val,
        input  mode,
        output div_n_clk,
        output load_ack,
        output load_err,
        output pending
    );

endinterface

// File: rtl/fq_div_prog.sv
// ---------------------------------------------------------------------------
// fq_div_prog
//
// Purpose: runtime-programmable clock divider. Produces either a one-cycle
// pulse or a near-50% square wave every DIV cycles of org_clk. New divisor
// and mode values are staged by a load request and only take effect at a
// period boundary (wrap edge), so the output never produces a runt pulse.
//
// Ports:
//   org_clk : source clock, all logic on its rising edge
//   rst_n   : asynchronous active-low reset
//   bus     : fq_div_prog_if.slave
//             en, load, div_val, mode          (inputs)
//             div_n_clk, load_ack, load_err,
//             pending                          (registered outputs)
//
// Parameters:
//   CNT_W        : width of divisor and period counter
//   DEFAULT_DIV  : divisor active out of reset (>= 2, < 2^CNT_W)
//   DEFAULT_MODE : mode active out of reset (0 = pulse, 1 = square)
// ---------------------------------------------------------------------------
module fq_div_prog #(
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned DEFAULT_DIV  = 2,
    parameter bit          DEFAULT_MODE = 1'b0
) (
    input  logic          org_clk,
    input  logic          rst_n,
    fq_div_prog_if.slave  bus
);

    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

    // Output level for a given counter position under a given divisor/mode.
    // Square-mode high threshold is computed one bit wider so that a divisor
    // of 2^CNT_W-1 does not wrap (div+1) to zero.
    function automatic logic wave_level(
        input logic [CNT_W-1:0] cnt,
        input logic [CNT_W-1:0] div,
        input logic             sq
    );
        logic [CNT_W:0] hi;
        hi = ({1'b0, div} + {{CNT_W{1'b0}}, 1'b1}) >> 1;
        if (sq) begin
            return ({1'b0, cnt} < hi);
        end
        return (cnt == (div - ONE));
    endfunction

    // Registered state
    logic [CNT_W-1:0] count_q,    count_d;
    logic [CNT_W-1:0] act_div_q,  act_div_d;
    logic             act_mode_q, act_mode_d;
    logic             pending_q,  pending_d;
    logic             out_q,      out_d;
    logic             ack_q,      ack_d;
    logic             err_q,      err_d;

    // Staged settings carry no reset: they are only consumed while
    // pending_q is set, and pending_q is cleared by reset.
    logic [CNT_W-1:0] stg_div_q;
    logic             stg_mode_q;

    logic             wrap;
    logic             load_ok;

    always_comb begin
        wrap    = bus.en && (count_q == (act_div_q - ONE));
        load_ok = bus.load && (bus.div_val >= TWO);

        count_d    = count_q;
        act_div_d  = act_div_q;
        act_mode_d = act_mode_q;
        pending_d  = pending_q;

        if (!bus.en) begin
            // Parking at act_div-1 makes the first enabled edge a wrap edge,
            // which restarts the period cleanly and applies staged settings.
            count_d = act_div_q - ONE;
        end else if (wrap) begin
            count_d = '0;
            if (pending_q) begin
                act_div_d  = stg_div_q;
                act_mode_d = stg_mode_q;
                pending_d  = 1'b0;
            end
        end else begin
            count_d = count_q + ONE;
        end

        // A load on the same edge as an apply stages the new values after
        // the old ones have been consumed, so pending stays set.
        if (load_ok) begin
            pending_d = 1'b1;
        end

        // Output derives from next-state values so it lines up with count_q
        // in the following cycle, including the first period after a switch.
        out_d = bus.en && wave_level(count_d, act_div_d, act_mode_d);
        ack_d = wrap && pending_q;
        err_d = bus.load && (bus.div_val < TWO);
    end

    always_ff @(posedge org_clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= DEF_DIV - ONE;
            act_div_q  <= DEF_DIV;
            act_mode_q <= DEFAULT_MODE;
            pending_q  <= 1'b0;
            out_q      <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            act_div_q  <= act_div_d;
            act_mode_q <= act_mode_d;
            pending_q  <= pending_d;
            out_q      <= out_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge org_clk) begin
        if (load_ok) begin
            stg_div_q  <= bus.div_val;
            stg_mode_q <= bus.mode;
        end
    end

    assign bus.div_n_clk = out_q;
    assign bus.load_ack  = ack_q;
    assign bus.load_err  = err_q;
    assign bus.pending   = pending_q;

endmodule

// File: tb/tb_fq_div_prog.sv
// ---------------------------------------------------------------------------
// tb_fq_div_prog
//
// Bench for fq_div_prog. A stimulus process drives directed and random
// sequences; after each rising edge a period-level reference model predicts
// {div_n_clk, load_ack, load_err, pending} and pushes it into a queue. A
// separate monitor pops one expectation per falling edge and compares.
// ---------------------------------------------------------------------------
module tb_fq_div_prog;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned DEF_DIV = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    fq_div_prog_if #(.CNT_W(CNT_W)) dif ();

    fq_div_prog #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEF_DIV),
        .DEFAULT_MODE(1'b0)
    ) dut (
        .org_clk(clk),
        .rst_n  (rst_n),
        .bus    (dif)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [3:0] exp_q[$];

    // Reference model: position within the current period (-1 = not in a
    // period), the active divisor/mode, and the list of loads accepted since
    // the last boundary (only the newest is applied).
    longint m_div;
    longint m_pos;
    bit     m_mode;
    longint stg_div[$];
    bit     stg_mode[$];

    function automatic void check(input string name, input logic [3:0] got,
                                  input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b expected=%b ({div_n_clk,load_ack,load_err,pending}) t=%0t",
                     name, got, exp, $time);
        end
    endfunction

    task automatic model_step();
        bit out_e, ack_e, err_e;
        out_e = 1'b0;
        ack_e = 1'b0;
        err_e = 1'b0;
        if (!rst_n) begin
            m_div  = DEF_DIV;
            m_mode = 1'b0;
            m_pos  = -1;
            stg_div.delete();
            stg_mode.delete();
        end else begin
            if (dif.en) begin
                if (m_pos < 0 || m_pos == m_div - 1) begin
                    if (stg_div.size() > 0) begin
                        m_div  = stg_div[$];
                        m_mode = stg_mode[$];
                        stg_div.delete();
                        stg_mode.delete();
                        ack_e  = 1'b1;
                    end
                    m_pos = 0;
                end else begin
                    m_pos++;
                end
                if (m_mode)
                    out_e = (m_pos < (m_div + 1) / 2);
                else
                    out_e = (m_pos == m_div - 1);
            end else begin
                m_pos = -1;
            end
            if (dif.load) begin
                if (longint'(dif.div_val) >= 2) begin
                    stg_div.push_back(longint'(dif.div_val));
                    stg_mode.push_back(dif.mode);
                end else begin
                    err_e = 1'b1;
                end
            end
        end
        exp_q.push_back({out_e, ack_e, err_e, (stg_div.size() != 0)});
    endtask

    task automatic cycle(input bit r, input bit e, input bit l,
                         input int unsigned dv, input bit md);
        @(negedge clk);
        rst_n       = r;
        dif.en      = e;
        dif.load    = l;
        dif.div_val = CNT_W'(dv);
        dif.mode    = md;
        @(posedge clk);
        model_step();
    endtask

    task automatic run(input int n, input bit e);
        repeat (n) cycle(1'b1, e, 1'b0, 0, 1'b0);
    endtask

    task automatic ld(input int unsigned dv, input bit md);
        cycle(1'b1, 1'b1, 1'b1, dv, md);
    endtask

    // Reset asserted between edges: outputs must drop without waiting for
    // the clock.
    task automatic async_reset_check();
        @(negedge clk);
        dif.en   = 1'b1;
        dif.load = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("async_rst", {dif.div_n_clk, dif.load_ack, dif.load_err, dif.pending}, 4'b0000);
        @(posedge clk);
        model_step();
    endtask

    // Monitor
    initial begin : monitor
        logic [3:0] e;
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("cyc%0d", n),
                      {dif.div_n_clk, dif.load_ack, dif.load_err, dif.pending}, e);
                n++;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        dif.en      = 1'b0;
        dif.load    = 1'b0;
        dif.div_val = '0;
        dif.mode    = 1'b0;
        #1 rst_n = 1'b0;

        // Reset held, then default pulse mode /4
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 0, 1'b0);
        run(13, 1'b1);

        // Switch to square /5 mid-period
        ld(5, 1'b1);
        run(16, 1'b1);

        // Square /2 then /3
        ld(2, 1'b1);
        run(9, 1'b1);
        ld(3, 1'b1);
        run(10, 1'b1);

        // Rejected loads
        ld(1, 1'b0);
        run(3, 1'b1);
        ld(0, 1'b1);
        run(6, 1'b1);

        // Disable for 7 cycles with a load of /6 while parked
        run(3, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 6, 1'b0);
        run(3, 1'b0);
        run(14, 1'b1);

        // Two loads before the boundary: only the last applies
        ld(8, 1'b0);
        ld(3, 1'b0);
        run(10, 1'b1);

        // Mid-period reset while output high and a load is pending
        ld(7, 1'b1);
        run(1, 1'b0);
        run(2, 1'b1);
        ld(9, 1'b0);
        async_reset_check();
        cycle(1'b0, 1'b0, 1'b0, 0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 0, 1'b0);
        run(12, 1'b1);

        // Largest divisor in square mode: high threshold must not wrap
        ld(32'h0000_FFFF, 1'b1);
        run(1, 1'b0);
        run(6, 1'b1);
        ld(3, 1'b0);
        run(1, 1'b0);
        run(8, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'b1, ($urandom_range(0, 9) != 0), ($urandom_range(0, 7) == 0),
                  $urandom_range(0, 9), 1'($urandom_range(0, 1)));
        end
        run(4, 1'b1);

        repeat (3) @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: expectations left=%0d required=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
